multiplier_sequencer_8_bit: RTL and testbench
=============================================

# multiplier_sequencer_8_bit

Sequential datapath and control for the 8-bit signed shift-add multiplier. It holds the X, A and B registers and steps through eight add/subtract-then-shift iterations. It drives the 9-bit adder/subtractor stage (`adder_subtractor_9_bit`) and consumes its `Sum` output. The 16-bit two's-complement product ends in A:B, with X holding the sign extension.

## Interface
- No parameters: the width is fixed at 8 bits.
- `Clk` input 1: system clock; all state updates on the rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Run` input 1: level-sensitive start request, synchronous to `Clk`.
- `ClearA_LoadB` input 1: synchronous load request; honoured only in IDLE.
- `S` input 8: switch value. It is the multiplier source on load and the multiplicand during the run.
- `Aval` output 8: A register, the upper product byte.
- `Bval` output 8: B register, the lower product byte.
- `X` output 1: sign-extension bit of A.
- `Done` output 1: high while in HOLD.
- Internal adder instance inputs: A operand = A register, B operand = `S`, `Subtract_Enable` = (ADD state && cnt==7).
- Internal adder output: 9-bit `Sum` (`Cout` unused).

## Operation
- States:
  - IDLE
  - ADD
  - SHIFT
  - HOLD
- 3-bit iteration counter `cnt`.
- Reset (asynchronous, `Reset_n`=0):
  - state=IDLE, cnt=0.
  - A=0x00, B=0x00, X=0, Done=0.
- IDLE:
  - `ClearA_LoadB`=1 → A<=0, X<=0, B<=S; stay in IDLE. Load has priority over `Run` in the same cycle, and `Run` is ignored that cycle.
  - `Run`=1 (with `ClearA_LoadB`=0) → A<=0, X<=0, cnt<=0, B retained; go to ADD.
- ADD:
  - If B[0]=1: {X,A} <= Sum[8:0], where Sum = sext(A) + sext(S), or sext(A) − sext(S) when cnt==7.
  - If B[0]=0: X, A, B unchanged.
  - Always go to SHIFT.
- SHIFT:
  - Arithmetic right shift of the 17-bit {X,A,B}: X keeps its value, A<={X,A[7:1]}, B<={A[0],B[7:1]}.
  - If cnt==7 → HOLD; else cnt<=cnt+1 and go to ADD.
- HOLD:
  - Done=1; registers frozen; `ClearA_LoadB` ignored.
  - `Run`=0 → IDLE. `Run` held high stays in HOLD, so there is no auto-restart.
- Consecutive multiply: after returning to IDLE, a new `Run` without a load multiplies the retained B (the previous low byte) by the current `S`.
- Arithmetic:
  - All values are two's complement.
  - The 9-bit sum never overflows for 8-bit operands, so no saturation is applied.
  - The final subtract implements the negative weight of multiplier bit 7.
- `S` must be stable from the `Run` sample through HOLD. The result is undefined if `S` changes mid-operation.

## Timing
- Run accepted at edge 0; ADD/SHIFT pairs occupy edges 1–16; Done=1 after edge 16. Latency is 16 cycles from the first ADD.
- Outputs are registered, with no combinational path from inputs to outputs.
- `Done` falls on the edge after `Run` is sampled low.
- Reset mid-operation: all registers clear immediately (asynchronously). The operation is abandoned and the block returns to IDLE with no partial result retained.
- `ClearA_LoadB` asserted during ADD, SHIFT or HOLD has no effect.

## Test plan
- Reset: assert `Reset_n`=0 during SHIFT of iteration 3 → Aval=0x00, Bval=0x00, X=0, Done=0 immediately; next `Run` starts cleanly.
- Positive × positive: load B=0x3B (59), set S=0x07, Run → after 16 ADD/SHIFT cycles Aval=0x01, Bval=0x9D (413), X=0, Done=1.
- Negative multiplier: load B=0xC5 (−59), S=0x07 → Aval=0xFE, Bval=0x63 (−413), X=1.
- Negative × negative and extremes:
  - B=0xC5, S=0xF9 (−7) → Aval=0x01, Bval=0x9D, X=0.
  - B=0x80, S=0x80 → Aval=0x40, Bval=0x00, X=0.
- Handshake:
  - Hold `Run`=1 for 40 cycles → single operation, Done stays 1, outputs frozen.
  - Drop `Run`, raise it again with S=0x02 and no load → Bval=0x9D × 2 result: Aval=0xFF, Bval=0x3A, X=1.
- Load/run collision: in IDLE, assert `ClearA_LoadB` and `Run` together with S=0x05 → B=0x05, A=0, state remains IDLE. `ClearA_LoadB` pulsed during ADD → no change to B.

Source files
------------

// File: rtl/multiplier_sequencer_8_bit.sv
// Control and datapath for an 8-bit signed shift-add multiplier.
// The 16-bit product ends in A:B; X carries the sign extension of A.

module adder_subtractor_9_bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Subtract_Enable,
  output logic [8:0] Sum
);

  logic [8:0] a_ext;
  logic [8:0] b_ext;

  // Subtraction is two's complement: invert the extended operand and add one.
  assign a_ext = {A[7], A};
  assign b_ext = {B[7], B} ^ {9{Subtract_Enable}};
  assign Sum   = a_ext + b_ext + {8'd0, Subtract_Enable};

endmodule

module multiplier_sequencer_8_bit (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       X,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       x_reg;
  logic       done_reg;
  logic       sub_en;
  logic [8:0] sum;

  // Multiplier bit 7 carries negative weight, so the last iteration subtracts.
  assign sub_en = (state == ADD) && (cnt == 3'd7);

  adder_subtractor_9_bit u_addsub (
    .A               (a_reg),
    .B               (S),
    .Subtract_Enable (sub_en),
    .Sum             (sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      a_reg    <= 8'h00;
      b_reg    <= 8'h00;
      x_reg    <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a_reg <= 8'h00;
            x_reg <= 1'b0;
            b_reg <= S;
          end else if (Run) begin
            a_reg <= 8'h00;
            x_reg <= 1'b0;
            cnt   <= 3'd0;
            state <= ADD;
          end
        end
        ADD: begin
          if (b_reg[0]) begin
            {x_reg, a_reg} <= sum;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a_reg <= {x_reg, a_reg[7:1]};
          b_reg <= {a_reg[0], b_reg[7:1]};
          if (cnt == 3'd7) begin
            state    <= HOLD;
            done_reg <= 1'b1;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= ADD;
          end
        end
        HOLD: begin
          // Run must fall before a new operation can begin.
          if (!Run) begin
            state    <= IDLE;
            done_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval = a_reg;
  assign Bval = b_reg;
  assign X    = x_reg;
  assign Done = done_reg;

endmodule

// File: tb/tb_multiplier_sequencer_8_bit.sv
// Directed bench for multiplier_sequencer_8_bit with hand-computed products.

module tb_multiplier_sequencer_8_bit;

  logic       Clk;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Done;

  int checks;
  int errors;

  multiplier_sequencer_8_bit dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .Done         (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] a_exp, input logic [7:0] b_exp,
                              input logic x_exp, input logic done_exp);
    check_output({tag, "_a"}, Aval, a_exp);
    check_output({tag, "_b"}, Bval, b_exp);
    check_output({tag, "_x"}, {7'd0, X}, {7'd0, x_exp});
    check_output({tag, "_done"}, {7'd0, Done}, {7'd0, done_exp});
  endtask

  task automatic load_b(input logic [7:0] value);
    ClearA_LoadB = 1'b1;
    S            = value;
    @(posedge Clk);
    #1;
    ClearA_LoadB = 1'b0;
  endtask

  // Run is taken at edge 0; the product is complete after 16 further edges.
  task automatic run_mult(input logic [7:0] s_val);
    S   = s_val;
    Run = 1'b1;
    repeat (17) @(posedge Clk);
    #1;
  endtask

  task automatic drop_run(input string tag);
    Run = 1'b0;
    @(posedge Clk);
    #1;
    check_output({tag, "_done_fall"}, {7'd0, Done}, 8'h00);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    Reset_n      = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    #12;
    check_result("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // 59 x 7 = 413, with Run held for 40 extra cycles
    load_b(8'h3B);
    check_output("load_b", Bval, 8'h3B);
    run_mult(8'h07);
    check_result("pos_pos", 8'h01, 8'h9D, 1'b0, 1'b1);
    repeat (40) @(posedge Clk);
    #1;
    check_result("run_held", 8'h01, 8'h9D, 1'b0, 1'b1);
    drop_run("pos_pos");

    // Retained B 0x9D (-99) x 2 = -198
    run_mult(8'h02);
    check_result("consecutive", 8'hFF, 8'h3A, 1'b1, 1'b1);
    drop_run("consecutive");

    // -59 x 7 = -413
    load_b(8'hC5);
    run_mult(8'h07);
    check_result("neg_pos", 8'hFE, 8'h63, 1'b1, 1'b1);
    drop_run("neg_pos");

    // -59 x -7 = 413
    load_b(8'hC5);
    run_mult(8'hF9);
    check_result("neg_neg", 8'h01, 8'h9D, 1'b0, 1'b1);
    drop_run("neg_neg");

    // -128 x -128 = 16384
    load_b(8'h80);
    run_mult(8'h80);
    check_result("min_min", 8'h40, 8'h00, 1'b0, 1'b1);
    drop_run("min_min");

    // Load and Run together: load wins, no operation starts
    ClearA_LoadB = 1'b1;
    Run          = 1'b1;
    S            = 8'h05;
    @(posedge Clk);
    #1;
    ClearA_LoadB = 1'b0;
    Run          = 1'b0;
    check_result("collision", 8'h00, 8'h05, 1'b0, 1'b0);
    repeat (20) @(posedge Clk);
    #1;
    check_result("collision_idle", 8'h00, 8'h05, 1'b0, 1'b0);

    // Load pulse during ADD must not disturb B
    load_b(8'h3B);
    S   = 8'h07;
    Run = 1'b1;
    @(posedge Clk);
    #1;
    ClearA_LoadB = 1'b1;
    @(posedge Clk);
    #1;
    ClearA_LoadB = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    check_result("load_in_add", 8'h01, 8'h9D, 1'b0, 1'b1);
    drop_run("load_in_add");

    // Reset during SHIFT of iteration 3 clears everything at once
    load_b(8'h3B);
    S   = 8'h07;
    Run = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    Run     = 1'b0;
    #1;
    check_result("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    run_mult(8'h07);
    check_result("after_reset", 8'h00, 8'h00, 1'b0, 1'b1);
    drop_run("after_reset");
    load_b(8'h3B);
    run_mult(8'h07);
    check_result("after_reset_load", 8'h01, 8'h9D, 1'b0, 1'b1);
    drop_run("after_reset_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
